spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// SPI slave with per-pin synchronizers, runtime CPOL/CPHA, LSB-first words,
// a one-word TX holding buffer and burst support.
module spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              spi_sck,
    input  logic              spi_ss_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              underrun
);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                 state_reg, state_next;
    logic [SYNC_STAGES-1:0] sck_sync_reg, ss_sync_reg, mosi_sync_reg;
    logic                   sck_prev_reg, ss_prev_reg;
    logic                   cpol_reg, cpha_reg;
    logic [CW-1:0]          cnt_reg;
    logic [DATA_W-1:0]      tx_shift_reg, rx_shift_reg, hold_reg, rx_data_reg;
    logic                   hold_full_reg, rx_valid_reg;

    logic sck_s, ss_s, mosi_s;
    logic ss_fall, ss_rise, sck_edge, leading, trailing;
    logic sample_edge, shift_edge, last_bit, load, accept;
    logic [DATA_W-1:0] rx_word;

    always_ff @(posedge sclk) begin
        if (!rst) begin
            sck_sync_reg  <= '0;
            ss_sync_reg   <= '1;
            mosi_sync_reg <= '0;
            sck_prev_reg  <= 1'b0;
            ss_prev_reg   <= 1'b1;
        end else begin
            sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], spi_sck};
            ss_sync_reg   <= {ss_sync_reg[SYNC_STAGES-2:0], spi_ss_n};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
            sck_prev_reg  <= sck_s;
            ss_prev_reg   <= ss_s;
        end
    end

    assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
    assign ss_s     = ss_sync_reg[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_reg[SYNC_STAGES-1];
    assign ss_fall  = ss_prev_reg & ~ss_s;
    assign ss_rise  = ~ss_prev_reg & ss_s;
    assign sck_edge = sck_s ^ sck_prev_reg;
    assign leading  = sck_edge & (sck_prev_reg == cpol_reg);
    assign trailing = sck_edge & (sck_s == cpol_reg);
    assign last_bit = (cnt_reg == CW'(DATA_W - 1));

    // A shift edge at count 0 is either the cpha=1 first leading edge or the
    // tail edge of the previous word in a cpha=0 burst; neither may shift.
    assign sample_edge = (state_reg == SHIFT) && (cpha_reg ? trailing : leading);
    assign shift_edge  = (state_reg == SHIFT) && (cpha_reg ? leading : trailing)
                         && (cnt_reg != '0);
    assign load        = (state_reg == LOAD) && !ss_rise;
    assign accept      = tx_valid && (!hold_full_reg || load);

    always_comb begin
        rx_word          = rx_shift_reg;
        rx_word[cnt_reg] = mosi_s;
    end

    always_ff @(posedge sclk) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (ss_rise) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (ss_fall) state_next = LOAD;
                LOAD:    state_next = SHIFT;
                SHIFT:   if (sample_edge && last_bit) state_next = LOAD;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy        = (state_reg != IDLE);
        spi_miso_oe = (state_reg != IDLE);
        spi_miso    = (state_reg != IDLE) ? tx_shift_reg[0] : 1'b0;
        underrun    = (state_reg == LOAD) && !hold_full_reg;
    end

    always_ff @(posedge sclk) begin
        if (!rst) begin
            cpol_reg      <= 1'b0;
            cpha_reg      <= 1'b0;
            cnt_reg       <= '0;
            tx_shift_reg  <= '0;
            rx_shift_reg  <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            if (ss_fall) begin
                cpol_reg <= cpol;
                cpha_reg <= cpha;
            end

            if (ss_rise) begin
                tx_shift_reg <= '0;
            end else if (load) begin
                tx_shift_reg <= hold_full_reg ? hold_reg : '0;
            end else if (shift_edge) begin
                tx_shift_reg <= {1'b0, tx_shift_reg[DATA_W-1:1]};
            end

            // Loading frees the buffer first, so a same-cycle accept refills it.
            if (accept) begin
                hold_reg      <= tx_data;
                hold_full_reg <= 1'b1;
            end else if (load) begin
                hold_full_reg <= 1'b0;
            end

            if (ss_rise || ss_fall) begin
                cnt_reg      <= '0;
                rx_shift_reg <= '0;
            end else if (sample_edge) begin
                rx_shift_reg <= rx_word;
                if (last_bit) begin
                    cnt_reg      <= '0;
                    rx_data_reg  <= rx_word;
                    rx_valid_reg <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end
        end
    end

    assign tx_ready = !hold_full_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
endmodule
